// File: rtl/half_cdc_arb.sv
// Round-robin arbiter merging NUM_SRC valid/ready sources onto one registered,
// source-tagged lane that feeds the half_cdc t0 port.
module half_cdc_arb #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned SRC_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        en_mask,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC-1:0]        s_valid,
    input  logic [NUM_SRC-1:0]        s_last,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_valid,
    output logic                      o_last,
    output logic [SRC_W-1:0]          o_src,
    input  logic                      o_ready,
    output logic                      grant_active
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   last_idx;
    logic [CNT_W-1:0]   beat_cnt;

    logic [NUM_SRC-1:0] req;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   rr_idx;
    logic               g_valid;
    logic               g_last;
    logic [DATA_W-1:0]  g_data;
    logic               load;
    logic               accept;
    logic               burst_end;
    logic               release_grant;

    assign req           = s_valid & en_mask;
    assign load          = !o_valid || o_ready;
    assign accept        = (state == GRANT) && g_valid && load;
    assign burst_end     = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign release_grant = g_last || burst_end;
    assign grant_active  = (state == GRANT);

    // Mux the granted source's beat.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (grant_idx == SRC_W'(i)) begin
                g_valid = s_valid[i];
                g_last  = s_last[i];
                g_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin search from last_idx+1; scanning downward lets the nearest hit win.
    always_comb begin
        pick   = '0;
        rr_idx = '0;
        for (int i = int'(NUM_SRC); i >= 1; i--) begin
            rr_idx = SRC_W'((int'(last_idx) + i) % int'(NUM_SRC));
            if (req[rr_idx]) begin
                pick = rr_idx;
            end
        end
    end

    always_comb begin
        s_ready = '0;
        if (state == GRANT) begin
            s_ready[grant_idx] = load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_idx  <= SRC_W'(NUM_SRC - 1);
            beat_cnt  <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
            o_src     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx <= pick;
                        beat_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (release_grant) begin
                            state    <= IDLE;
                            last_idx <= grant_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: load on accept, drain when consumed, hold under backpressure.
            if (accept) begin
                o_data  <= g_data;
                o_src   <= grant_idx;
                o_valid <= 1'b1;
                o_last  <= release_grant;
            end else if (load) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_half_cdc_arb.sv
// Directed and randomized bench for half_cdc_arb against a transaction-level
// model: per-source packet queues, round-robin winner prediction, output register.
module tb_half_cdc_arb;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          xl;
    } beat_t;

    logic             clk;
    logic             reset;
    logic [NS-1:0]    en_mask;
    logic [NS*DW-1:0] s_data;
    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_last;
    logic [NS-1:0]    s_ready;
    logic [DW-1:0]    o_data;
    logic             o_valid;
    logic             o_last;
    logic [1:0]       o_src;
    logic             o_ready;
    logic             grant_active;

    half_cdc_arb #(.NUM_SRC(NS), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .en_mask(en_mask),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_src(o_src),
        .o_ready(o_ready), .grant_active(grant_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t         srcq [NS][$];
    logic [NS-1:0] gate;
    int            checks, errors, edge_n;
    bit            arb_pend;
    int            prev_owner, exp_win, owner;
    bit            ev;
    int            esrc;
    logic [DW-1:0] ed;
    logic          el;
    int            acc_edge[$];
    int            acc_src[$];
    int            beats_in, beats_out;
    int            exp_mb[13] = '{2, 2, 2, 2, 1, 1, 1, 2, 2, 2, 2, 2, 2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_next(input int p, input logic [NS-1:0] r);
        for (int k = 1; k <= NS; k++) begin
            if (r[(p + k) % NS]) return (p + k) % NS;
        end
        return -1;
    endfunction

    task automatic add_beat(input int s, input logic [DW-1:0] d, input logic l, input logic xl);
        beat_t b;
        b.d = d; b.l = l; b.xl = xl;
        srcq[s].push_back(b);
        beats_in++;
    endtask

    // Beat k of a packet closes a grant at packet end or every MB beats into the packet.
    task automatic add_pkt(input int s, input int len);
        for (int k = 0; k < len; k++)
            add_beat(s, DW'($urandom), (k == len - 1), (k == len - 1) || ((k + 1) % MB == 0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) srcq[i].delete();
        arb_pend = 1; prev_owner = NS - 1; exp_win = -1; owner = -1;
        ev = 0; beats_in = 0; beats_out = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                s_valid[i] = gate[i];
                s_data[i*DW +: DW] = srcq[i][0].d;
                s_last[i] = srcq[i][0].l;
            end else begin
                s_valid[i] = 1'b0;
                s_data[i*DW +: DW] = '0;
                s_last[i] = 1'b0;
            end
        end
    endtask

    task automatic sample_and_model();
        logic          load;
        logic [NS-1:0] req;
        int            a;
        beat_t         b;
        load = !ev || o_ready;
        chk("o_valid", 64'(o_valid), 64'(ev));
        if (ev) begin
            chk("o_src", 64'(o_src), 64'(esrc));
            chk("o_data", 64'(o_data), 64'(ed));
            chk("o_last", 64'(o_last), 64'(el));
        end
        chk("s_ready_onehot", 64'($countones(s_ready) <= 1), 64'(1));
        if (!load) chk("s_ready_stall", 64'(s_ready), 64'(0));
        req = s_valid & en_mask;
        if (arb_pend && exp_win < 0 && req != '0) exp_win = rr_next(prev_owner, req);
        if (ev && o_ready) beats_out++;
        a = -1;
        for (int i = 0; i < NS; i++) if (s_valid[i] && s_ready[i]) a = i;
        if (a >= 0) begin
            if (arb_pend) begin
                chk("grant_src", 64'(a), 64'(exp_win));
                arb_pend = 0; exp_win = -1; owner = a;
            end else begin
                chk("owner_src", 64'(a), 64'(owner));
            end
            chk("grant_active", 64'(grant_active), 64'(1));
            b = srcq[a].pop_front();
            acc_edge.push_back(edge_n + 1);
            acc_src.push_back(a);
            ev = 1; esrc = a; ed = b.d; el = b.xl;
            if (b.xl) begin
                arb_pend = 1; prev_owner = a;
            end
        end else if (load) begin
            ev = 0;
        end
    endtask

    task automatic cycle();
        logic r;
        drive();
        @(negedge clk);
        r = reset;
        if (!r) sample_and_model();
        @(posedge clk);
        edge_n++;
        if (r) model_reset();
        #1;
    endtask

    function automatic bit busy_now();
        bit b;
        b = ev;
        for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input int budget);
        for (int n = 0; n < budget && busy_now(); n++) cycle();
        chk("drain_done", 64'(busy_now()), 64'(0));
    endtask

    task automatic clear_log();
        acc_edge.delete();
        acc_src.delete();
    endtask

    initial begin
        int e0, n0, s;
        checks = 0; errors = 0; edge_n = 0;
        reset = 1'b1; o_ready = 1'b1; en_mask = '1; gate = '1;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'(0));
        chk("rst_o_data", 64'(o_data), 64'(0));
        chk("rst_o_last", 64'(o_last), 64'(0));
        chk("rst_o_src", 64'(o_src), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_grant_active", 64'(grant_active), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Single source, three beats, one arbitration cycle then back-to-back accepts.
        clear_log();
        e0 = edge_n + 1;
        add_beat(0, 32'h2, 1'b0, 1'b0);
        add_beat(0, 32'h20, 1'b0, 1'b0);
        add_beat(0, 32'hdeadbeef, 1'b1, 1'b1);
        repeat (6) cycle();
        chk("t1_count", 64'(acc_src.size()), 64'(3));
        for (int k = 0; k < 3 && k < acc_src.size(); k++) begin
            chk("t1_edge", 64'(acc_edge[k]), 64'(e0 + 1 + k));
            chk("t1_src", 64'(acc_src[k]), 64'(0));
        end

        // Round robin over four single-beat requesters, one bubble between grants.
        clear_log();
        for (int r = 0; r < 2; r++) for (int i = 0; i < NS; i++) add_pkt(i, 1);
        drain(100);
        chk("rr_count", 64'(acc_src.size()), 64'(8));
        for (int k = 0; k < 8 && k < acc_src.size(); k++) begin
            chk("rr_src", 64'(acc_src[k]), 64'((1 + k) % NS));
            if (k > 0) chk("rr_gap", 64'(acc_edge[k] - acc_edge[k-1]), 64'(2));
        end

        // Burst split: src2 10-beat packet interleaved with src1 3-beat packet.
        clear_log();
        add_pkt(2, 10);
        cycle();
        add_pkt(1, 3);
        drain(200);
        chk("mb_count", 64'(acc_src.size()), 64'(13));
        for (int k = 0; k < 13 && k < acc_src.size(); k++)
            chk("mb_src", 64'(acc_src[k]), 64'(exp_mb[k]));

        // Backpressure for five cycles mid-packet.
        clear_log();
        add_pkt(3, 6);
        repeat (3) cycle();
        o_ready = 1'b0;
        n0 = acc_src.size();
        chk("bp_pre", 64'(n0), 64'(2));
        repeat (5) cycle();
        chk("bp_no_accept", 64'(acc_src.size()), 64'(n0));
        chk("bp_hold_valid", 64'(o_valid), 64'(1));
        o_ready = 1'b1;
        drain(100);
        chk("bp_count", 64'(acc_src.size()), 64'(6));

        // Enable mask: only src1/src3; dropping src1 mid-grant lets it finish.
        clear_log();
        en_mask = 4'b1010;
        for (int i = 0; i < NS; i++) add_pkt(i, 3);
        repeat (2) cycle();
        en_mask = 4'b1000;
        repeat (12) cycle();
        chk("en_count", 64'(acc_src.size()), 64'(6));
        for (int k = 0; k < 6 && k < acc_src.size(); k++)
            chk("en_src", 64'(acc_src[k]), 64'((k < 3) ? 1 : 3));
        en_mask = '1;
        drain(100);

        // Reset in the middle of a granted burst.
        for (int i = 0; i < NS; i++) add_pkt(i, 8);
        repeat (4) cycle();
        chk("rst_mid_busy", 64'(grant_active), 64'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive();
        #1;
        chk("rst_mid_o_valid", 64'(o_valid), 64'(0));
        chk("rst_mid_s_ready", 64'(s_ready), 64'(0));
        chk("rst_mid_grant_active", 64'(grant_active), 64'(0));
        clear_log();
        for (int i = 0; i < NS; i++) add_pkt(i, 1);
        drain(100);
        chk("rst_next_count", 64'(acc_src.size()), 64'(4));
        if (acc_src.size() > 0) chk("rst_next_src0", 64'(acc_src[0]), 64'(0));

        // Random traffic, valid gaps, backpressure and enable changes.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) begin
                s = int'($urandom_range(NS - 1));
                if (srcq[s].size() < 24) add_pkt(s, int'($urandom_range(10, 1)));
            end
            for (int i = 0; i < NS; i++) gate[i] = ($urandom_range(3) != 0);
            o_ready = ($urandom_range(2) != 0);
            if ($urandom_range(31) == 0) en_mask = NS'($urandom);
            cycle();
        end
        gate = '1; en_mask = '1; o_ready = 1'b1;
        drain(2000);
        chk("beat_count", 64'(beats_out), 64'(beats_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_cdc_arb.md
# half_cdc_arb

Round-robin arbiter sharing one 32-bit valid/ready lane between NUM_SRC requesters, in front of the `half_cdc` target (t0) port. Grants are held for a packet (until `last`) or for at most MAX_BURST beats, whichever comes first. The merged stream carries a source tag so the far side of the crossing can demultiplex. Everything runs in the full-rate `clk` domain; the output is registered.

## Interface
- NUM_SRC, 4, number of requesters (2..8)
- DATA_W, 32, beat width
- MAX_BURST, 16, max beats per grant (1..256)
- SRC_W, $clog2(NUM_SRC), tag width (derived, not overridden)
- clk  input  1  system clock (same clock that drives `half_cdc` clk)
- reset  input  1  synchronous, active-high
- en_mask  input  NUM_SRC  per-source enable; sampled only at arbitration
- s_data  input  NUM_SRC*DATA_W  source beats, source i at [i*DATA_W +: DATA_W]
- s_valid  input  NUM_SRC  source valid
- s_last  input  NUM_SRC  source end-of-packet
- s_ready  output  NUM_SRC  source ready, combinational
- o_data  output  DATA_W  merged beat, registered; connects to `half_cdc` t0_data
- o_valid  output  1  registered; connects to t0_valid
- o_last  output  1  registered end-of-packet/burst
- o_src  output  SRC_W  registered index of beat's source
- o_ready  input  1  from t0_ready
- grant_active  output  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Registers: state, grant_idx, last_idx, beat_cnt, output register.
- IDLE: req = s_valid & en_mask. If req nonzero, grant_idx <= first set bit searching from last_idx+1 upward, wrapping modulo NUM_SRC; beat_cnt <= 0; state <= GRANT. If req zero, stay. s_ready all 0 in IDLE.
- load = !o_valid || o_ready.
- GRANT: s_ready[grant_idx] = load; every other s_ready bit 0. Accept = s_valid[grant_idx] && s_ready[grant_idx].
- On accept: o_data <= s_data[grant_idx]; o_src <= grant_idx; o_valid <= 1; o_last <= s_last[grant_idx] || (beat_cnt == MAX_BURST-1); beat_cnt <= beat_cnt+1.
- Release: on an accepted beat with s_last or beat_cnt == MAX_BURST-1 -> state <= IDLE, last_idx <= grant_idx.
- No accept and load -> o_valid <= 0. o_valid && !o_ready -> output register holds all fields.
- Granted source dropping s_valid mid-grant: grant held, no timeout.
- en_mask changes mid-grant do not revoke the current grant. They only affect the next arbitration.
- A burst split by MAX_BURST marks o_last=1 on its final beat. The source resumes its packet on a later grant, tagged by o_src.
- beat_cnt width $clog2(MAX_BURST+1); never wraps (reset to 0 on each grant).

## Timing
- Reset values: state IDLE, last_idx NUM_SRC-1 (source 0 wins first), grant_idx 0, beat_cnt 0, o_valid 0, o_data 0, o_last 0, o_src 0, s_ready 0, grant_active 0.
- Arbitration: one IDLE cycle per grant. First beat accepted in the cycle after req is seen. Appears on o_* the cycle after accept (latency 1).
- Sustained throughput within a grant: 1 beat/clk while o_ready=1. Between grants: 1 bubble.
- Back-to-back grants to the same source are allowed if it is the only requester.
- Reset asserted mid-grant: all state returns to reset values the next edge. The in-flight output beat is discarded.
- `half_cdc` accepts at the half-clock rate. o_ready backpressure is the only coupling; no half_clock input.

## Test plan
- Single source: src0 sends 3 beats 0x2, 0x20, 0xdeadbeef (last on third), o_ready=1 -> o_* shows the same 3 beats on consecutive cycles, o_src=0, o_last only on 0xdeadbeef; IDLE 1 cycle before first accept.
- Round-robin fairness: all 4 sources valid, single-beat packets, o_ready=1 -> o_src sequence 0,1,2,3,0,1..., each beat separated by one bubble.
- MAX_BURST=4, src2 sends 10-beat packet, src1 also requesting -> src2 beats 0-3 (o_last on beat 3), src1 packet, src2 beats 4-7, and so on; data order per source preserved.
- Backpressure: o_ready low for 5 cycles mid-packet -> o_data/o_src/o_last stable, s_ready[grant]=0, no beat lost or duplicated; resume on o_ready=1.
- en_mask=4'b1010 with all valid -> only src1/src3 granted. Clearing bit 1 mid-grant of src1 -> src1 finishes its packet, then src3 granted.
- Reset asserted during a granted burst -> next cycle o_valid=0, s_ready=0, grant_active=0. Next arbitration with all valid grants src0.
